// File: rtl/serdes_err_inject.sv
// Block-level error injector between a SERDES transmit and receive path.
// Corrupts sync headers and/or single payload bits with an LFSR-driven probability, with bursts and statistics.
module serdes_err_inject #(
    parameter int          DATA_WIDTH   = 64,
    parameter int          HDR_WIDTH    = 2,
    parameter int          THRESH_WIDTH = 16,
    parameter int          CNT_WIDTH    = 32,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [HDR_WIDTH-1:0]    in_hdr,
    input  logic                    in_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [HDR_WIDTH-1:0]    out_hdr,
    output logic                    out_valid,
    input  logic                    cfg_enable,
    input  logic                    cfg_hdr_en,
    input  logic                    cfg_data_en,
    input  logic [THRESH_WIDTH-1:0] cfg_threshold,
    input  logic [7:0]              cfg_burst_len,
    input  logic [CNT_WIDTH-1:0]    cfg_block_limit,
    input  logic                    cnt_clear,
    output logic [CNT_WIDTH-1:0]    cnt_blocks,
    output logic [CNT_WIDTH-1:0]    cnt_hdr_err,
    output logic [CNT_WIDTH-1:0]    cnt_data_err,
    output logic                    done,
    output logic                    in_burst
);
    localparam int          IDX_W = $clog2(DATA_WIDTH);
    localparam logic [31:0] SEED  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, BURST, DONE} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic [7:0]              rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;
    logic                    out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]    cnt_blocks_q, cnt_blocks_d;
    logic [CNT_WIDTH-1:0]    cnt_hdr_err_q, cnt_hdr_err_d;
    logic [CNT_WIDTH-1:0]    cnt_data_err_q, cnt_data_err_d;
    logic                    done_q, done_d;
    logic                    in_burst_q, in_burst_d;

    logic                    active;
    logic                    trigger;
    logic                    corrupt;
    logic                    limit_hit;
    logic [IDX_W-1:0]        bit_idx;
    logic [CNT_WIDTH-1:0]    blk_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        active    = cfg_enable && in_valid && (state_q == RUN || state_q == BURST);
        trigger   = (state_q == RUN) && (lfsr_q[THRESH_WIDTH-1:0] < cfg_threshold);
        corrupt   = active && (state_q == BURST || trigger);
        bit_idx   = lfsr_q[16+IDX_W-1:16];
        blk_inc   = sat_inc(cnt_blocks_q);
        // A same-cycle clear wipes the count, so the limit cannot be considered reached.
        limit_hit = active && (cfg_block_limit != '0) && (blk_inc == cfg_block_limit) && !cnt_clear;

        state_d     = state_q;
        lfsr_d      = lfsr_q;
        rem_d       = rem_q;
        out_valid_d = in_valid;
        out_data_d  = in_data;
        out_hdr_d   = in_hdr;

        if (corrupt && cfg_hdr_en)
            out_hdr_d = lfsr_q[31] ? '1 : '0;
        if (corrupt && cfg_data_en)
            out_data_d = in_data ^ ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_idx);

        if (active)
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

        if (!cfg_enable) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (corrupt && cfg_burst_len > 8'd1) begin
                        state_d = BURST;
                        rem_d   = cfg_burst_len - 8'd1;
                    end
                end
                BURST: begin
                    if (active) begin
                        rem_d = rem_q - 8'd1;
                        if (rem_q <= 8'd1) begin
                            state_d = RUN;
                            rem_d   = '0;
                        end
                    end
                end
                DONE: if (cnt_clear) state_d = RUN;
                default: state_d = IDLE;
            endcase
            if (limit_hit) begin
                state_d = DONE;
                rem_d   = '0;
            end
        end

        cnt_blocks_d   = cnt_blocks_q;
        cnt_hdr_err_d  = cnt_hdr_err_q;
        cnt_data_err_d = cnt_data_err_q;
        if (cnt_clear) begin
            cnt_blocks_d   = '0;
            cnt_hdr_err_d  = '0;
            cnt_data_err_d = '0;
        end else if (active) begin
            cnt_blocks_d = blk_inc;
            if (corrupt && cfg_hdr_en)  cnt_hdr_err_d  = sat_inc(cnt_hdr_err_q);
            if (corrupt && cfg_data_en) cnt_data_err_d = sat_inc(cnt_data_err_q);
        end

        done_d     = (state_d == DONE);
        in_burst_d = (state_d == BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lfsr_q         <= SEED;
            rem_q          <= '0;
            out_data_q     <= '0;
            out_hdr_q      <= '0;
            out_valid_q    <= 1'b0;
            cnt_blocks_q   <= '0;
            cnt_hdr_err_q  <= '0;
            cnt_data_err_q <= '0;
            done_q         <= 1'b0;
            in_burst_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            rem_q          <= rem_d;
            out_data_q     <= out_data_d;
            out_hdr_q      <= out_hdr_d;
            out_valid_q    <= out_valid_d;
            cnt_blocks_q   <= cnt_blocks_d;
            cnt_hdr_err_q  <= cnt_hdr_err_d;
            cnt_data_err_q <= cnt_data_err_d;
            done_q         <= done_d;
            in_burst_q     <= in_burst_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_hdr      = out_hdr_q;
    assign out_valid    = out_valid_q;
    assign cnt_blocks   = cnt_blocks_q;
    assign cnt_hdr_err  = cnt_hdr_err_q;
    assign cnt_data_err = cnt_data_err_q;
    assign done         = done_q;
    assign in_burst     = in_burst_q;
endmodule

// File: tb/tb_serdes_err_inject.sv
// Scoreboard bench for serdes_err_inject: a reference model queues expected outputs per valid block,
// a monitor pops and compares them whenever out_valid is seen.
module tb_serdes_err_inject;
    localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_hdr = '0;
    logic        in_valid = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        out_valid;
    logic        cfg_enable = 1'b0, cfg_hdr_en = 1'b0, cfg_data_en = 1'b0;
    logic [15:0] cfg_threshold = '0;
    logic [7:0]  cfg_burst_len = '0;
    logic [31:0] cfg_block_limit = '0;
    logic        cnt_clear = 1'b0;
    logic [31:0] cnt_blocks, cnt_hdr_err, cnt_data_err;
    logic        done, in_burst;

    serdes_err_inject #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .THRESH_WIDTH(16), .CNT_WIDTH(32), .LFSR_SEED(32'h0000_0001)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid),
        .cfg_enable(cfg_enable), .cfg_hdr_en(cfg_hdr_en), .cfg_data_en(cfg_data_en),
        .cfg_threshold(cfg_threshold), .cfg_burst_len(cfg_burst_len),
        .cfg_block_limit(cfg_block_limit), .cnt_clear(cnt_clear),
        .cnt_blocks(cnt_blocks), .cnt_hdr_err(cnt_hdr_err), .cnt_data_err(cnt_data_err),
        .done(done), .in_burst(in_burst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  h;
        logic        done;
        logic        burst;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_lfsr;
    int          m_mode, m_rem;
    int          m_blocks, m_herr, m_derr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 32'h1; m_mode = M_IDLE; m_rem = 0;
        m_blocks = 0; m_herr = 0; m_derr = 0;
    endtask

    // Reference behaviour for one clock, using the inputs just driven.
    task automatic model_step();
        exp_t e;
        logic corrupt;
        int   nmode;
        e.d = in_data; e.h = in_hdr; e.done = 1'b0; e.burst = 1'b0;
        corrupt = 1'b0;
        nmode = m_mode;
        if (!cfg_enable) begin
            nmode = M_IDLE; m_rem = 0;
        end else if (m_mode == M_IDLE) begin
            nmode = M_RUN;
        end else if (m_mode == M_DONE) begin
            if (cnt_clear) nmode = M_RUN;
        end else if (in_valid) begin
            corrupt = (m_mode == M_BURST) || (m_lfsr[15:0] < cfg_threshold);
            if (corrupt && cfg_hdr_en)  e.h = m_lfsr[31] ? 2'b11 : 2'b00;
            if (corrupt && cfg_data_en) e.d[m_lfsr[21:16]] = ~e.d[m_lfsr[21:16]];
            if (m_mode == M_BURST) begin
                m_rem--;
                if (m_rem == 0) nmode = M_RUN;
            end else if (corrupt && cfg_burst_len > 1) begin
                nmode = M_BURST; m_rem = cfg_burst_len - 1;
            end
            m_blocks++;
            if (corrupt && cfg_hdr_en)  m_herr++;
            if (corrupt && cfg_data_en) m_derr++;
            if (cfg_block_limit != 0 && m_blocks == cfg_block_limit && !cnt_clear) begin
                nmode = M_DONE; m_rem = 0;
            end
            m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
        end
        if (cnt_clear) begin m_blocks = 0; m_herr = 0; m_derr = 0; end
        m_mode = nmode;
        if (in_valid) begin
            e.done  = (nmode == M_DONE);
            e.burst = (nmode == M_BURST);
            q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, model it, return just after the capturing edge.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [1:0] h);
        @(negedge clk);
        in_valid = v; in_data = d; in_hdr = h;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic blocks(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) cyc(1'b1, {$urandom, $urandom}, h);
    endtask

    // Reset applied with a valid block on the inputs to show it is ignored.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0123_4567; in_hdr = 2'b01;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst out_data", out_data, 64'h0);
        chk("rst out_hdr", {62'h0, out_hdr}, 64'h0);
        chk("rst out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst counters", {32'h0, cnt_blocks | cnt_hdr_err | cnt_data_err}, 64'h0);
        chk("rst flags", {62'h0, done, in_burst}, 64'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected out_valid at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_hdr", {62'h0, out_hdr}, {62'h0, e.h});
                    chk("done/in_burst", {62'h0, done, in_burst}, {62'h0, e.done, e.burst});
                end
            end
        end
    end

    initial begin : stim
        model_reset();
        do_reset();

        // Threshold 0: pure pass-through, then disable holds the counters.
        cfg_enable = 1'b1; cfg_threshold = 16'd0;
        cyc(1'b0, 64'h0, 2'b10);
        blocks(1000, 2'b10);
        chk("t0 cnt_blocks", {32'h0, cnt_blocks}, 64'd1000);
        chk("t0 err counters", {cnt_hdr_err, cnt_data_err}, 64'h0);
        cfg_enable = 1'b0;
        blocks(3, 2'b10);
        chk("disable holds cnt_blocks", {32'h0, cnt_blocks}, 64'd1000);

        // Header corruption at ~1% probability against the LFSR model.
        do_reset();
        cfg_enable = 1'b1; cfg_hdr_en = 1'b1; cfg_threshold = 16'd655;
        cyc(1'b0, 64'h0, 2'b01);
        blocks(20000, 2'b01);
        chk("hdr cnt_blocks", {32'h0, cnt_blocks}, 64'd20000);
        chk("hdr cnt_hdr_err model", {32'h0, cnt_hdr_err}, 64'(m_herr));
        chk("hdr cnt_data_err", {32'h0, cnt_data_err}, 64'h0);
        checks++;
        if (cnt_hdr_err < 120 || cnt_hdr_err > 300) begin
            errors++;
            $display("FAIL hdr err rate: got %0d expected 120..300", cnt_hdr_err);
        end

        // Data-only corruption at 50%.
        do_reset();
        cfg_hdr_en = 1'b0; cfg_data_en = 1'b1; cfg_threshold = 16'h8000;
        cyc(1'b0, 64'h0, 2'b10);
        blocks(200, 2'b10);
        chk("data cnt_data_err model", {32'h0, cnt_data_err}, 64'(m_derr));
        chk("data cnt_hdr_err", {32'h0, cnt_hdr_err}, 64'h0);
        chk("data errors seen", {63'h0, cnt_data_err != 0}, 64'h1);

        // Burst of 4 from one forced trigger (seed low bits 0x0001), idle gaps in between.
        do_reset();
        cfg_hdr_en = 1'b1; cfg_data_en = 1'b1; cfg_burst_len = 8'd4;
        cyc(1'b0, 64'h0, 2'b10);
        cfg_threshold = 16'hFFFF;
        cyc(1'b1, 64'h1111_2222_3333_4444, 2'b10);
        cfg_threshold = 16'd0;
        cyc(1'b0, 64'h0, 2'b10);
        chk("burst gap1 in_burst", {63'h0, in_burst}, 64'h1);
        cyc(1'b1, 64'h5555_6666_7777_8888, 2'b01);
        cyc(1'b0, 64'h0, 2'b10);
        cyc(1'b0, 64'h0, 2'b10);
        chk("burst gap2 in_burst", {63'h0, in_burst}, 64'h1);
        cyc(1'b1, 64'h9999_AAAA_BBBB_CCCC, 2'b10);
        cyc(1'b0, 64'h0, 2'b10);
        chk("burst gap3 in_burst", {63'h0, in_burst}, 64'h1);
        cyc(1'b1, 64'hDDDD_EEEE_FFFF_0000, 2'b01);
        chk("burst end in_burst", {63'h0, in_burst}, 64'h0);
        cyc(1'b1, 64'h0123_4567_89AB_CDEF, 2'b10);
        chk("burst cnt_data_err", {32'h0, cnt_data_err}, 64'd4);
        chk("burst cnt_hdr_err", {32'h0, cnt_hdr_err}, 64'd4);
        chk("burst cnt_blocks", {32'h0, cnt_blocks}, 64'd5);

        // Block limit 500, then clear.
        do_reset();
        cfg_burst_len = 8'd1; cfg_block_limit = 32'd500;
        cyc(1'b0, 64'h0, 2'b10);
        blocks(500, 2'b10);
        chk("limit done", {63'h0, done}, 64'h1);
        chk("limit cnt_blocks", {32'h0, cnt_blocks}, 64'd500);
        blocks(10, 2'b10);
        chk("limit holds cnt_blocks", {32'h0, cnt_blocks}, 64'd500);
        cnt_clear = 1'b1;
        cyc(1'b0, 64'h0, 2'b10);
        cnt_clear = 1'b0;
        chk("clear done", {63'h0, done}, 64'h0);
        chk("clear cnt_blocks", {32'h0, cnt_blocks}, 64'h0);
        cyc(1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 2'b10);
        chk("after clear counts", {32'h0, cnt_blocks}, 64'd1);
        cfg_block_limit = 32'd0;

        // Clear on the same cycle as corrupted blocks.
        do_reset();
        cfg_threshold = 16'hFFFF;
        cyc(1'b0, 64'h0, 2'b10);
        blocks(3, 2'b10);
        cnt_clear = 1'b1;
        cyc(1'b1, 64'hFEDC_BA98_7654_3210, 2'b01);
        cnt_clear = 1'b0;
        chk("clear+inc cnt_blocks", {32'h0, cnt_blocks}, 64'h0);
        chk("clear+inc err counters", {cnt_hdr_err, cnt_data_err}, 64'h0);

        // Reset in the middle of a burst; LFSR restarts from the seed afterwards.
        cfg_burst_len = 8'd8;
        blocks(2, 2'b10);
        chk("pre-rst in_burst", {63'h0, in_burst}, 64'h1);
        do_reset();
        cfg_burst_len = 8'd1;
        cyc(1'b0, 64'h0, 2'b10);
        cyc(1'b1, 64'h0, 2'b10);
        chk("seed restart hdr", {62'h0, out_hdr}, 64'h0);
        chk("seed restart data", out_data, 64'h1);
        blocks(20, 2'b10);

        cyc(1'b0, 64'h0, 2'b10);
        cyc(1'b0, 64'h0, 2'b10);
        chk("scoreboard drained", 64'(q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
